// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: one 32-bit schedule word per cycle into a 15 x 128 b round-key file.
// Full expansion takes 52 cycles after key_load; reads are never stalled (1-cycle latency when REG_READ=1).
module aes256_key_expand #(
  parameter int REG_READ = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] key_in,
  input  logic         key_load,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         busy,
  output logic         keys_ready
);

  // Row r holds S-box entries 16r..16r+15, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_t;

  function automatic logic [7:0] f_sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] f_subword(input logic [31:0] x);
    return {f_sbox(x[31:24]), f_sbox(x[23:16]), f_sbox(x[15:8]), f_sbox(x[7:0])};
  endfunction

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_step;
  logic [5:0]     r_idx;
  logic [31:0]    r_win [8];
  logic [127:0]   r_rk  [15];

  logic [31:0]    w_prev;
  logic [31:0]    w_sub;
  logic [7:0]     w_rcon;
  logic [31:0]    w_t;
  logic [31:0]    w_new;
  logic [127:0]   w_rd;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // key_load overrides everything, including an expansion in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    busy        = 1'b0;
    keys_ready  = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_IDLE;
      S_EXPAND: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_idx == 6'd59) w_state_nxt = S_DONE;
      end
      S_DONE: keys_ready = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
    if (key_load) begin
      w_state_nxt = S_EXPAND;
      w_step      = 1'b0;
    end
  end

  always_comb begin
    w_rcon = 8'h00;
    case (r_idx[5:3])
      3'd1:    w_rcon = 8'h01;
      3'd2:    w_rcon = 8'h02;
      3'd3:    w_rcon = 8'h04;
      3'd4:    w_rcon = 8'h08;
      3'd5:    w_rcon = 8'h10;
      3'd6:    w_rcon = 8'h20;
      3'd7:    w_rcon = 8'h40;
      default: w_rcon = 8'h00;
    endcase
  end

  // r_win[0] is w[i-8], r_win[7] is w[i-1].
  assign w_prev = r_win[7];
  assign w_sub  = f_subword((r_idx[2:0] == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev);

  always_comb begin
    w_t = w_prev;
    if (r_idx[2:0] == 3'd0)      w_t = w_sub ^ {w_rcon, 24'h000000};
    else if (r_idx[2:0] == 3'd4) w_t = w_sub;
  end

  assign w_new = r_win[0] ^ w_t;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= 6'd0;
      for (int k = 0; k < 8; k++)  r_win[k] <= 32'h0;
      for (int r = 0; r < 15; r++) r_rk[r]  <= 128'h0;
    end else if (key_load) begin
      r_idx    <= 6'd8;
      for (int k = 0; k < 8; k++) r_win[k] <= key_in[255 - 32*k -: 32];
      r_rk[0]  <= key_in[255:128];
      r_rk[1]  <= key_in[127:0];
    end else if (w_step) begin
      r_idx <= r_idx + 6'd1;
      for (int k = 0; k < 7; k++) r_win[k] <= r_win[k+1];
      r_win[7] <= w_new;
      // Word slot 0 lands in the top 32 bits of the round key.
      r_rk[r_idx[5:2]][{~r_idx[1:0], 5'b00000} +: 32] <= w_new;
    end
  end

  always_comb begin
    w_rd = 128'h0;
    if (rk_addr != 4'd15) w_rd = r_rk[rk_addr];
  end

  generate
    if (REG_READ != 0) begin : g_rd_reg
      logic [127:0] r_rdata;
      always_ff @(posedge clk) begin
        if (reset) r_rdata <= 128'h0;
        else       r_rdata <= w_rd;
      end
      assign rk_data = r_rdata;
    end else begin : g_rd_comb
      assign rk_data = w_rd;
    end
  endgenerate

endmodule

// File: tb/tb_aes256_key_expand.sv
// Directed bench for aes256_key_expand: FIPS-197 vector, independent key-schedule model,
// reload/reset mid-expansion, read latency and out-of-range index.
module tb_aes256_key_expand;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] key_in;
  logic         key_load;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         busy;
  logic         keys_ready;

  int n_checks = 0;
  int n_errs   = 0;

  aes256_key_expand #(.REG_READ(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_load   (key_load),
    .rk_addr    (rk_addr),
    .rk_data    (rk_data),
    .busy       (busy),
    .keys_ready (keys_ready)
  );

  always #5 clk = ~clk;

  // FIPS-197 Appendix A.3 expansion of key 603deb10..0914dff4.
  logic [31:0] A3 [60] = '{
    32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
    32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4,
    32'h9ba35411, 32'h8e6925af, 32'ha51a8b5f, 32'h2067fcde,
    32'ha8b09c1a, 32'h93d194cd, 32'hbe49846e, 32'hb75d5b9a,
    32'hd59aecb8, 32'h5bf3c917, 32'hfee94248, 32'hde8ebe96,
    32'hb5a9328a, 32'h2678a647, 32'h98312229, 32'h2f6c79b3,
    32'h812c81ad, 32'hdadf48ba, 32'h24360af2, 32'hfab8b464,
    32'h98c5bfc9, 32'hbebd198e, 32'h268c3ba7, 32'h09e04214,
    32'h68007bac, 32'hb2df3316, 32'h96e939e4, 32'h6c518d80,
    32'hc814e204, 32'h76a9fb8a, 32'h5025c02d, 32'h59c58239,
    32'hde136967, 32'h6ccc5a71, 32'hfa256395, 32'h9674ee15,
    32'h5886ca5d, 32'h2e2f31d7, 32'h7e0af1fa, 32'h27cf73c3,
    32'h749c47ab, 32'h18501dda, 32'he2757e4f, 32'h7401905a,
    32'hcafaaae3, 32'he4d59b34, 32'h9adf6ace, 32'hbd10190d,
    32'hfe4890d1, 32'he6188d0b, 32'h046df344, 32'h706c631e
  };

  logic [7:0]  m_sbox [256];
  logic [31:0] m_w    [60];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15-n -: 8];
  endfunction

  // S-box built from GF(2^8) inversion plus the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      m_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {m_sbox[x[31:24]], m_sbox[x[23:16]], m_sbox[x[15:8]], m_sbox[x[7:0]]};
  endfunction

  task automatic model_sched(input logic [255:0] k);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < 8; i++) m_w[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = m_w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      m_w[i] = m_w[i-8] ^ t;
    end
  endtask

  task automatic load_key(input logic [255:0] k);
    key_in   = k;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
    rk_addr = a;
    @(posedge clk); #1;
    d = rk_data;
  endtask

  task automatic wait_ready(input int start, output int n);
    n = start;
    while (!keys_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [127:0] d;
    for (int r = 0; r < 15; r++) begin
      read_rk(4'(r), d);
      check($sformatf("%s_rk%0d", tag, r), d, {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]});
    end
  endtask

  initial begin
    logic [127:0] d;
    logic [255:0] ka, kb, k3;
    int           n;
    logic         seen;

    reset    = 1'b1;
    key_load = 1'b0;
    key_in   = '0;
    rk_addr  = 4'd0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  128'(busy), 128'h0);
    check("rst_ready", 128'(keys_ready), 128'h0);
    check("rst_data",  rk_data, 128'h0);
    reset = 1'b0;

    // FIPS-197 A.3; RK1 readable the cycle after the load edge.
    load_key({A3[0], A3[1], A3[2], A3[3], A3[4], A3[5], A3[6], A3[7]});
    read_rk(4'd1, d);
    check("e1_rk1",  d, {A3[4], A3[5], A3[6], A3[7]});
    check("e1_busy", 128'(busy), 128'h1);
    wait_ready(1, n);
    check("a3_latency", 128'(n), 128'd52);
    check("a3_busy_done", 128'(busy), 128'h0);
    for (int r = 0; r < 15; r++) begin
      read_rk(4'(r), d);
      check($sformatf("a3_rk%0d", r), d, {A3[4*r], A3[4*r+1], A3[4*r+2], A3[4*r+3]});
    end
    read_rk(4'd15, d);
    check("addr15", d, 128'h0);

    // Read sweep: output holds the previous index until the next edge.
    rk_addr = 4'd0;
    @(posedge clk); #1;
    for (int r = 1; r < 15; r++) begin
      rk_addr = 4'(r);
      #1;
      check($sformatf("hold_rk%0d", r - 1), rk_data, {A3[4*r-4], A3[4*r-3], A3[4*r-2], A3[4*r-1]});
      @(posedge clk); #1;
      check($sformatf("sweep_rk%0d", r), rk_data, {A3[4*r], A3[4*r+1], A3[4*r+2], A3[4*r+3]});
    end

    // key = 1 and random keys against the software model.
    load_key(256'd1);
    wait_ready(0, n);
    check("one_latency", 128'(n), 128'd52);
    model_sched(256'd1);
    check_model("one");
    for (int t = 0; t < 2; t++) begin
      k3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      load_key(k3);
      wait_ready(0, n);
      check($sformatf("rnd%0d_latency", t), 128'(n), 128'd52);
      model_sched(k3);
      check_model($sformatf("rnd%0d", t));
    end

    // Reload with key B on E20 of key A's expansion.
    ka = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    load_key(ka);
    repeat (19) @(posedge clk);
    #1;
    load_key(kb);
    wait_ready(0, n);
    check("reload_latency", 128'(n), 128'd52);
    model_sched(kb);
    check_model("reload");

    // Same key reloaded from DONE: full re-expansion; stray key_in ignored.
    load_key(kb);
    check("same_ready_drop", 128'(keys_ready), 128'h0);
    check("same_busy", 128'(busy), 128'h1);
    key_in = ~kb;
    wait_ready(0, n);
    check("same_latency", 128'(n), 128'd52);
    read_rk(4'd0, d);
    check("ignore_keyin", d, kb[255:128]);

    // Reset on E30.
    load_key(ka);
    repeat (29) @(posedge clk);
    #1;
    rk_addr = 4'd1;
    reset   = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy",  128'(busy), 128'h0);
    check("midrst_ready", 128'(keys_ready), 128'h0);
    check("midrst_data",  rk_data, 128'h0);
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      seen = seen | keys_ready | busy;
    end
    check("midrst_quiet", 128'(seen), 128'h0);
    read_rk(4'd3, d);
    check("midrst_rk3", d, 128'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
